// File: rtl/elbeth_mem_arbiter_pkg.sv
// elbeth_mem_arbiter_pkg: shared size codes, arbiter states and bus command.
// Imported by the arbiter and the alignment checker.
package elbeth_mem_arbiter_pkg;

  localparam logic [3:0] SIZE_BYTE     = 4'b0001;
  localparam logic [3:0] SIZE_HALFWORD = 4'b0011;
  localparam logic [3:0] SIZE_WORD     = 4'b1111;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUS_I,
    ARB_BUS_D,
    ARB_RESP
  } arb_state_e;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  size;
  } bus_cmd_t;

endpackage

// File: rtl/elbeth_align_check.sv
// elbeth_align_check: flags accesses whose address does not suit the size.
// Unknown size codes are always reported as misaligned.
module elbeth_align_check
  import elbeth_mem_arbiter_pkg::*;
(
  input  logic [3:0] size,
  input  logic [1:0] addr_lo,
  output logic       misaligned
);

  always_comb begin
    misaligned = 1'b1;
    unique case (1'b1)
      (size == SIZE_BYTE):     misaligned = 1'b0;
      (size == SIZE_HALFWORD): misaligned = addr_lo[0];
      (size == SIZE_WORD):     misaligned = |addr_lo;
      default:                 misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/elbeth_mem_arbiter.sv
// elbeth_mem_arbiter: shares one memory bus between fetch and data ports.
// One transaction at a time, with alignment check and bus timeout.
module elbeth_mem_arbiter
  import elbeth_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned MAX_D_GRANTS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_req,
  input  logic [31:0] imem_addr,
  output logic        imem_ready,
  output logic [31:0] imem_rdata,
  output logic        imem_error,
  input  logic        dmem_req,
  input  logic        dmem_wr,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_size,
  output logic        dmem_ready,
  output logic [31:0] dmem_rdata,
  output logic        dmem_error,
  output logic        mem_valid,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_size,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_error
);

  localparam logic [7:0] TMO_LOAD   = 8'(TIMEOUT);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_GRANTS);

  arb_state_e  state_q, state_d;
  bus_cmd_t    cmd_q, cmd_d;
  logic        mem_valid_q, mem_valid_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [3:0]  streak_q, streak_d;
  logic        i_ready_q, i_ready_d;
  logic        d_ready_q, d_ready_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        i_err_q, i_err_d;
  logic        d_err_q, d_err_d;

  logic        i_mis;
  logic        d_mis;
  logic        i_win;
  logic        d_win;
  logic        bus_end;
  logic [31:0] end_rdata;
  logic        end_err;

  elbeth_align_check u_i_align (
    .size       (SIZE_WORD),
    .addr_lo    (imem_addr[1:0]),
    .misaligned (i_mis)
  );

  elbeth_align_check u_d_align (
    .size       (dmem_size),
    .addr_lo    (dmem_addr[1:0]),
    .misaligned (d_mis)
  );

  // Data normally wins; a full streak of data grants yields to fetch.
  assign i_win = imem_req
               & (~dmem_req | (streak_q == STREAK_MAX));
  assign d_win = dmem_req & ~i_win;

  assign bus_end   = mem_ready | (tmo_q <= 8'd1);
  assign end_rdata = mem_ready ? mem_rdata : 32'd0;
  assign end_err   = mem_ready ? mem_error : 1'b1;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    mem_valid_d = mem_valid_q;
    tmo_d       = tmo_q;
    streak_d    = streak_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    i_rdata_d   = 32'd0;
    d_rdata_d   = 32'd0;
    i_err_d     = 1'b0;
    d_err_d     = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (i_win) begin
          streak_d = 4'd0;
          if (i_mis) begin
            i_ready_d = 1'b1;
            i_err_d   = 1'b1;
            state_d   = ARB_RESP;
          end else begin
            cmd_d.wr    = 1'b0;
            cmd_d.addr  = imem_addr;
            cmd_d.wdata = 32'd0;
            cmd_d.size  = SIZE_WORD;
            mem_valid_d = 1'b1;
            tmo_d       = TMO_LOAD;
            state_d     = ARB_BUS_I;
          end
        end else if (d_win) begin
          if (imem_req && streak_q < STREAK_MAX)
            streak_d = streak_q + 4'd1;
          if (d_mis) begin
            d_ready_d = 1'b1;
            d_err_d   = 1'b1;
            state_d   = ARB_RESP;
          end else begin
            cmd_d.wr    = dmem_wr;
            cmd_d.addr  = dmem_addr;
            cmd_d.wdata = dmem_wdata;
            cmd_d.size  = dmem_size;
            mem_valid_d = 1'b1;
            tmo_d       = TMO_LOAD;
            state_d     = ARB_BUS_D;
          end
        end
      end
      ARB_BUS_I, ARB_BUS_D: begin
        if (bus_end) begin
          mem_valid_d = 1'b0;
          tmo_d       = 8'd0;
          state_d     = ARB_RESP;
          if (state_q == ARB_BUS_D) begin
            d_ready_d = 1'b1;
            d_rdata_d = end_rdata;
            d_err_d   = end_err;
          end else begin
            i_ready_d = 1'b1;
            i_rdata_d = end_rdata;
            i_err_d   = end_err;
          end
        end else begin
          tmo_d = tmo_q - 8'd1;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      cmd_q       <= '0;
      mem_valid_q <= 1'b0;
      tmo_q       <= 8'd0;
      streak_q    <= 4'd0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_rdata_q   <= 32'd0;
      d_rdata_q   <= 32'd0;
      i_err_q     <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      mem_valid_q <= mem_valid_d;
      tmo_q       <= tmo_d;
      streak_q    <= streak_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_err_q     <= i_err_d;
      d_err_q     <= d_err_d;
    end
  end

  assign imem_ready = i_ready_q;
  assign imem_rdata = i_rdata_q;
  assign imem_error = i_err_q;
  assign dmem_ready = d_ready_q;
  assign dmem_rdata = d_rdata_q;
  assign dmem_error = d_err_q;
  assign mem_valid  = mem_valid_q;
  assign mem_wr     = cmd_q.wr;
  assign mem_addr   = cmd_q.addr;
  assign mem_wdata  = cmd_q.wdata;
  assign mem_size   = cmd_q.size;

endmodule

// File: tb/tb_elbeth_mem_arbiter.sv
// tb_elbeth_mem_arbiter: directed vectors and corner sequences for the
// memory arbiter, with a simple bus responder of configurable latency.
module tb_elbeth_mem_arbiter;

  localparam logic [3:0] SZ_B = 4'b0001;
  localparam logic [3:0] SZ_H = 4'b0011;
  localparam logic [3:0] SZ_W = 4'b1111;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_error;
  logic        dmem_req;
  logic        dmem_wr;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_size;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        dmem_error;
  logic        mem_valid;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_size;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_error;

  elbeth_mem_arbiter #(
    .TIMEOUT      (8),
    .MAX_D_GRANTS (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .imem_error (imem_error),
    .dmem_req   (dmem_req),
    .dmem_wr    (dmem_wr),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_size  (dmem_size),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .dmem_error (dmem_error),
    .mem_valid  (mem_valid),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_size   (mem_size),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .mem_error  (mem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  size;
    logic [31:0] wdata;
    logic [31:0] brd;
    logic        berr;
    int          lat;
    logic        xerr;
    logic [31:0] xrd;
    int          xcyc;
    int          xval;
  } vec_t;

  vec_t tbl[9];

  int n_cmp = 0;
  int n_bad = 0;

  int          n_rec;
  int          n_valid;
  int          rec_port[16];
  int          rec_cyc[16];
  logic [31:0] rec_rdata[16];
  logic        rec_err[16];
  logic [31:0] rec_addr[16];
  logic [31:0] rec_wdata[16];
  logic        rec_wr[16];
  logic [3:0]  rec_size[16];

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    mem_ready = 1'b0;
    mem_error = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Drives requests, answers the bus after lat valid cycles (0 = never),
  // and records each completion in order.
  task automatic run(input int n_i, input int n_d,
                     input logic [31:0] iaddr, input logic dwr,
                     input logic [31:0] daddr, input logic [3:0] dsz,
                     input logic [31:0] dwd, input logic [31:0] brd,
                     input logic berr, input int lat);
    int li;
    int ld;
    int vcnt;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_wr;
    logic [3:0]  c_size;
    li = n_i;
    ld = n_d;
    vcnt = 0;
    n_rec = 0;
    n_valid = 0;
    c_addr = 32'hFFFF_FFFF;
    c_wdata = 32'd0;
    c_wr = 1'b0;
    c_size = 4'd0;
    @(negedge clk);
    @(negedge clk);
    imem_addr = iaddr;
    dmem_wr = dwr;
    dmem_addr = daddr;
    dmem_size = dsz;
    dmem_wdata = dwd;
    mem_ready = 1'b0;
    mem_error = 1'b0;
    mem_rdata = 32'h5A5A_5A5A;
    imem_req = (li > 0);
    dmem_req = (ld > 0);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (mem_valid) begin
        vcnt++;
        n_valid++;
        if (vcnt == 1) begin
          c_addr = mem_addr;
          c_wdata = mem_wdata;
          c_wr = mem_wr;
          c_size = mem_size;
        end
      end else begin
        vcnt = 0;
      end
      mem_ready = mem_valid && lat > 0 && vcnt == lat;
      mem_rdata = mem_ready ? brd : 32'h5A5A_5A5A;
      mem_error = mem_ready ? berr : 1'b0;
      if (imem_ready || dmem_ready) begin
        chk("one_port_ready", {63'd0, imem_ready & dmem_ready}, 64'd0);
        if (n_rec < 16) begin
          rec_port[n_rec] = dmem_ready ? 1 : 0;
          rec_cyc[n_rec] = k;
          rec_rdata[n_rec] = dmem_ready ? dmem_rdata : imem_rdata;
          rec_err[n_rec] = dmem_ready ? dmem_error : imem_error;
          rec_addr[n_rec] = c_addr;
          rec_wdata[n_rec] = c_wdata;
          rec_wr[n_rec] = c_wr;
          rec_size[n_rec] = c_size;
          n_rec++;
        end
        if (dmem_ready) begin
          chk("i_quiet", {31'd0, imem_ready, imem_error, imem_rdata}, 64'd0);
          ld--;
        end else begin
          chk("d_quiet", {31'd0, dmem_ready, dmem_error, dmem_rdata}, 64'd0);
          li--;
        end
        c_addr = 32'hFFFF_FFFF;
      end
      imem_req = (li > 0);
      dmem_req = (ld > 0);
      if (li <= 0 && ld <= 0) break;
    end
    if (li > 0 || ld > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_bound: got %0d/%0d pending, expected 0/0", li, ld);
      imem_req = 1'b0;
      dmem_req = 1'b0;
    end
    mem_ready = 1'b0;
    mem_error = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    imem_req = 1'b0;
    imem_addr = 32'd0;
    dmem_req = 1'b0;
    dmem_wr = 1'b0;
    dmem_addr = 32'd0;
    dmem_wdata = 32'd0;
    dmem_size = SZ_W;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    mem_error = 1'b0;

    tbl[0] = '{1'b0, 32'h100, SZ_W, 32'h0, 32'h1234_5678, 1'b0, 1,
               1'b0, 32'h1234_5678, 2, 1};
    tbl[1] = '{1'b1, 32'h200, SZ_W, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b1, 1,
               1'b1, 32'hDEAD_BEEF, 2, 1};
    tbl[2] = '{1'b0, 32'h103, SZ_H, 32'h0, 32'h1111_1111, 1'b0, 1,
               1'b1, 32'h0, 1, 0};
    tbl[3] = '{1'b0, 32'h102, SZ_H, 32'h0, 32'hAAAA_5555, 1'b0, 3,
               1'b0, 32'hAAAA_5555, 4, 3};
    tbl[4] = '{1'b0, 32'h3, SZ_B, 32'h0, 32'h0000_00EE, 1'b0, 2,
               1'b0, 32'h0000_00EE, 3, 2};
    tbl[5] = '{1'b0, 32'h102, SZ_W, 32'h0, 32'h2222_2222, 1'b0, 1,
               1'b1, 32'h0, 1, 0};
    tbl[6] = '{1'b1, 32'h0, 4'h7, 32'h1, 32'h0, 1'b0, 1,
               1'b1, 32'h0, 1, 0};
    tbl[7] = '{1'b1, 32'h10, SZ_H, 32'h0000_BEEF, 32'h0, 1'b0, 1,
               1'b0, 32'h0, 2, 1};
    tbl[8] = '{1'b0, 32'h400, SZ_W, 32'h0, 32'h3333_3333, 1'b0, 0,
               1'b1, 32'h0, 9, 8};

    @(negedge clk);
    @(negedge clk);
    chk("rst_ctl", {57'd0, mem_valid, mem_wr, imem_ready, imem_error,
        dmem_ready, dmem_error, 1'b0}, 64'd0);
    chk("rst_addr", {mem_addr, mem_wdata}, 64'd0);
    chk("rst_rdata", {imem_rdata, dmem_rdata}, 64'd0);
    chk("rst_size", {60'd0, mem_size}, 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run(0, 1, 32'h0, tbl[i].wr, tbl[i].addr, tbl[i].size,
          tbl[i].wdata, tbl[i].brd, tbl[i].berr, tbl[i].lat);
      chk($sformatf("v%0d_cyc", i), 64'(rec_cyc[0]), 64'(tbl[i].xcyc));
      chk($sformatf("v%0d_err", i), {63'd0, rec_err[0]}, {63'd0, tbl[i].xerr});
      chk($sformatf("v%0d_rdata", i), {32'd0, rec_rdata[0]}, {32'd0, tbl[i].xrd});
      chk($sformatf("v%0d_nvalid", i), 64'(n_valid), 64'(tbl[i].xval));
      if (tbl[i].xval > 0) begin
        chk($sformatf("v%0d_cmd", i),
            {rec_addr[0], rec_wdata[0]}, {tbl[i].addr, tbl[i].wdata});
        chk($sformatf("v%0d_wrsz", i), {59'd0, rec_wr[0], rec_size[0]},
            {59'd0, tbl[i].wr, tbl[i].size});
      end
    end

    // Simultaneous requests: data first, fetch after a 2-cycle bus gap.
    do_reset();
    run(1, 1, 32'h40, 1'b0, 32'h100, SZ_W, 32'h0, 32'h0BAD_F00D, 1'b0, 1);
    chk("sim_order", {62'd0, rec_port[0][0], rec_port[1][0]}, 64'd2);
    chk("sim_addr", {rec_addr[0], rec_addr[1]}, {32'h100, 32'h40});
    chk("sim_cyc", {32'(rec_cyc[0]), 32'(rec_cyc[1])}, {32'd2, 32'd5});
    chk("sim_rdata", {rec_rdata[0], rec_rdata[1]},
        {32'h0BAD_F00D, 32'h0BAD_F00D});

    // Data streak: four data grants, one fetch, then data resumes.
    do_reset();
    run(1, 6, 32'h80, 1'b0, 32'h500, SZ_W, 32'h0, 32'h7777_0000, 1'b0, 1);
    chk("streak_nrec", 64'(n_rec), 64'd7);
    begin
      logic [6:0] seq;
      seq = '0;
      for (int i = 0; i < 7; i++) seq[i] = rec_port[i][0];
      chk("streak_seq", {57'd0, seq}, {57'd0, 7'b110_1111});
    end
    chk("streak_iaddr", {32'd0, rec_addr[4]}, {32'd0, 32'h80});

    // Fetch with no bus answer times out after 8 valid cycles.
    run(1, 0, 32'h44, 1'b0, 32'h0, SZ_W, 32'h0, 32'h5A5A_5A5A, 1'b0, 0);
    chk("tmo_nvalid", 64'(n_valid), 64'd8);
    chk("tmo_cyc", 64'(rec_cyc[0]), 64'd9);
    chk("tmo_resp", {31'd0, rec_err[0], rec_rdata[0]}, {31'd0, 1'b1, 32'd0});

    // Misaligned fetch never reaches the bus.
    run(1, 0, 32'h41, 1'b0, 32'h0, SZ_W, 32'h0, 32'h0, 1'b0, 1);
    chk("imis_cyc", 64'(rec_cyc[0]), 64'd1);
    chk("imis_resp", {31'd0, rec_err[0], rec_rdata[0]}, {31'd0, 1'b1, 32'd0});
    chk("imis_nvalid", 64'(n_valid), 64'd0);

    // Reset while a store is on the bus, then a clean fetch.
    @(negedge clk);
    @(negedge clk);
    dmem_wr = 1'b1;
    dmem_addr = 32'h300;
    dmem_wdata = 32'h1357_9BDF;
    dmem_size = SZ_W;
    dmem_req = 1'b1;
    @(negedge clk);
    chk("mid_bus", {31'd0, mem_valid, mem_addr}, {31'd0, 1'b1, 32'h300});
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ctl", {57'd0, mem_valid, mem_wr, imem_ready, imem_error,
        dmem_ready, dmem_error, 1'b0}, 64'd0);
    chk("mid_rst_cmd", {mem_addr, mem_wdata}, 64'd0);
    chk("mid_rst_rd", {imem_rdata, dmem_rdata}, 64'd0);
    chk("mid_rst_sz", {60'd0, mem_size}, 64'd0);
    rst = 1'b1;
    dmem_req = 1'b0;
    @(negedge clk);
    chk("mid_idle", {62'd0, mem_valid, dmem_ready}, 64'd0);
    run(1, 0, 32'h88, 1'b0, 32'h0, SZ_W, 32'h0, 32'h600D_CAFE, 1'b0, 1);
    chk("post_rst_fetch", {31'd0, rec_err[0], rec_rdata[0]},
        {31'd0, 1'b0, 32'h600D_CAFE});
    chk("post_rst_cyc", {32'(rec_cyc[0]), rec_addr[0]}, {32'd2, 32'h88});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
